// File: rtl/dma_reg_bus_master_if.sv
// Request/response channels and register-bus signals of the DMA register-bus master.
// The master modport is the DUT view; the slave modport is the environment view.
interface dma_reg_bus_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        output req_ready, rsp_valid, rsp_rdata, wr_en, rd_en, addr, wdata, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_en, rd_en, addr, wdata, busy
    );
endinterface

// File: rtl/dma_reg_bus_master.sv
// DMA register-bus master: queues register requests in a FIFO, issues one-cycle
// bus strobes in order, and returns read data on a valid/ready response channel.
module dma_reg_bus_master #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_reg_bus_master_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RSP} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop;
    req_t             head;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_nxt;

    logic              wr_en_d, rd_en_d, rsp_valid_d, req_ready_d, busy_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rsp_rdata_d;

    // req_ready is registered from occupancy, so a full FIFO refuses pushes even while popping
    assign push = bus.req_valid && bus.req_ready;
    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // Next state; a strobe is high exactly while in ISSUE, and rd_en tells which kind
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.rd_en) begin
                    state_nxt = RD_WAIT;
                    lat_nxt   = LAT_W'(RD_LATENCY);
                end else if (count != '0) begin
                    pop = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_W'(1)) state_nxt = RSP;
                else                      lat_nxt   = lat_cnt - LAT_W'(1);
            end
            RSP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        wr_en_d     = pop && head.write;
        rd_en_d     = pop && !head.write;
        addr_d      = pop ? head.addr : '0;
        wdata_d     = (pop && head.write) ? head.wdata : '0;
        rsp_valid_d = bus.rsp_valid;
        rsp_rdata_d = bus.rsp_rdata;
        if (state == RD_WAIT && lat_cnt == LAT_W'(1)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.rdata;
        end
        if (state == RSP && bus.rsp_ready) rsp_valid_d = 1'b0;
        req_ready_d = (count_nxt != CNT_W'(FIFO_DEPTH));
        busy_d      = (count_nxt != '0) || (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en     <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.addr      <= '0;
            bus.wdata     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            bus.wr_en     <= wr_en_d;
            bus.rd_en     <= rd_en_d;
            bus.addr      <= addr_d;
            bus.wdata     <= wdata_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_rdata <= rsp_rdata_d;
            bus.req_ready <= req_ready_d;
            bus.busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_dma_reg_bus_master.sv
// Directed bench for dma_reg_bus_master: table of single transactions against a small
// register-file slave, plus hand-written back-to-back, full/blocking, ordering and reset cases.
module tb_dma_reg_bus_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_reg_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dma_reg_bus_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RD_LATENCY(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    strobe_t     slog[$];
    logic [31:0] smem [16];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int push_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file slave: read data appears the cycle after rd_en
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) smem[i] <= '0;
            bus.rdata <= '0;
        end else begin
            if (bus.wr_en) smem[bus.addr[5:2]] <= bus.wdata;
            if (bus.rd_en) bus.rdata <= smem[bus.addr[5:2]];
        end
    end

    // Bus monitor: logs every strobe cycle and checks bus-level invariants
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en || bus.rd_en) begin
                chk("strobe_excl", 64'(bus.wr_en & bus.rd_en), 64'(0));
                if (bus.rd_en) chk("rd_wdata_zero", 64'(bus.wdata), 64'(0));
                slog.push_back('{wr: bus.wr_en, rd: bus.rd_en, addr: bus.addr, wdata: bus.wdata, cyc: cyc});
            end else begin
                chk("idle_bus_zero", {bus.addr, bus.wdata}, 64'(0));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the push edge
    task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("push_timeout", 64'(1), 64'(0));
        @(negedge clk);
        push_cyc = cyc;
    endtask

    task automatic wait_strobe(output strobe_t s);
        int n = 0;
        while (slog.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (slog.size() == 0) begin
            chk("strobe_timeout", 64'(1), 64'(0));
            s.wr = 1'b0; s.rd = 1'b0; s.addr = '0; s.wdata = '0; s.cyc = -1;
        end else begin
            s = slog.pop_front();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
    endtask

    // Waits for the response, checks latency and hold under back-pressure, then handshakes
    task automatic check_rsp(input string tag, input int rd_cyc, input logic [31:0] exp);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(rd_cyc + 2));
        chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(exp));
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_hold"}, 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({1'b1, exp}));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_release"}, 64'(bus.rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t    vt[8];
        strobe_t s;
        int      p0;
        int      hs_cyc;

        vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b0, 32'h04, 32'h0,        32'h0};
        vt[2] = '{1'b1, 32'h04, 32'h12345678, 32'h0};
        vt[3] = '{1'b0, 32'h04, 32'h0,        32'h12345678};
        vt[4] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vt[5] = '{1'b1, 32'h3C, 32'hFFFFFFFF, 32'h0};
        vt[6] = '{1'b0, 32'h3C, 32'h0,        32'hFFFFFFFF};
        vt[7] = '{1'b1, 32'h00, 32'h00000001, 32'h0};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        hs_cyc = 0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("rst_strobes", 64'({bus.wr_en, bus.rd_en}), 64'(0));
        chk("rst_addr_wdata", {bus.addr, bus.wdata}, 64'(0));
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));

        // Single transactions from the table
        for (int i = 0; i < 8; i++) begin
            push_req(vt[i].w, vt[i].a, vt[i].d);
            bus.req_valid = 1'b0;
            wait_strobe(s);
            chk("t_lat", 64'(s.cyc), 64'(push_cyc + 1));
            chk("t_kind", 64'({s.wr, s.rd}), 64'({vt[i].w, !vt[i].w}));
            chk("t_addr", 64'(s.addr), 64'(vt[i].a));
            chk("t_wdata", 64'(s.wdata), 64'(vt[i].w ? vt[i].d : 32'h0));
            if (vt[i].w) begin
                @(negedge clk);
                chk("t_no_rsp", 64'(bus.rsp_valid), 64'(0));
            end else begin
                check_rsp("t_rd", s.cyc, vt[i].exp_rd);
            end
            wait_idle("t");
            chk("t_one_strobe", 64'(slog.size()), 64'(0));
        end

        // Back-to-back writes
        p0 = 0;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 32'(4 * i), 32'hB0B00000 + 32'(i));
            if (i == 0) p0 = push_cyc;
            chk("b2b_ready", 64'(bus.req_ready), 64'(1));
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(s);
            chk("b2b_cyc", 64'(s.cyc), 64'(p0 + 1 + i));
            chk("b2b_addr", 64'({s.wr, s.addr}), 64'({1'b1, 32'(4 * i)}));
        end
        wait_idle("b2b");

        // Read followed by five writes while the response is back-pressured
        fork
            begin
                push_req(1'b0, 32'h10, 32'h0);
                for (int i = 0; i < 5; i++) push_req(1'b1, 32'h20 + 32'(4 * i), 32'h11110000 + 32'(i));
                bus.req_valid = 1'b0;
            end
            begin
                repeat (12) @(negedge clk);
                chk("blk_ready_low", 64'(bus.req_ready), 64'(0));
                chk("blk_one_strobe", 64'(slog.size()), 64'(1));
                chk("blk_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({1'b1, 32'hDEADBEEF}));
                if (slog.size() > 0) begin
                    s = slog.pop_front();
                    chk("blk_rd", 64'({s.rd, s.addr}), 64'({1'b1, 32'h10}));
                end
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                bus.rsp_ready = 1'b0;
                hs_cyc = cyc;
            end
        join
        for (int i = 0; i < 5; i++) begin
            wait_strobe(s);
            if (i == 0) chk("blk_resume", 64'(s.cyc), 64'(hs_cyc + 1));
            chk("blk_wr", 64'({s.wr, s.addr, s.wdata[15:0]}), 64'({1'b1, 32'h20 + 32'(4 * i), 16'(i)}));
        end
        wait_idle("blk");

        // Mixed ordering: write, read, write
        push_req(1'b1, 32'h20, 32'hAAAA0020);
        push_req(1'b0, 32'h24, 32'h0);
        push_req(1'b1, 32'h28, 32'hAAAA0028);
        bus.req_valid = 1'b0;
        wait_strobe(s);
        chk("mix_w1", 64'({s.wr, s.addr}), 64'({1'b1, 32'h20}));
        wait_strobe(s);
        chk("mix_r", 64'({s.rd, s.addr}), 64'({1'b1, 32'h24}));
        check_rsp("mix_rsp", s.cyc, 32'h11110001);
        chk("mix_blocked", 64'(slog.size()), 64'(0));
        hs_cyc = cyc;
        wait_strobe(s);
        chk("mix_w2", 64'({s.wr, s.addr}), 64'({1'b1, 32'h28}));
        chk("mix_w2_cyc", 64'(s.cyc), 64'(hs_cyc + 1));
        wait_idle("mix");

        // Reset during RD_WAIT with a write still queued
        push_req(1'b0, 32'h3C, 32'h0);
        push_req(1'b1, 32'h30, 32'h5);
        bus.req_valid = 1'b0;
        wait_strobe(s);
        chk("rstm_rd", 64'({s.rd, s.addr}), 64'({1'b1, 32'h3C}));
        if (cyc == s.cyc) @(negedge clk);
        chk("rstm_busy_before", 64'(bus.busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_strobes", 64'({bus.wr_en, bus.rd_en}), 64'(0));
        chk("rstm_addr_wdata", {bus.addr, bus.wdata}, 64'(0));
        chk("rstm_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'(0));
        chk("rstm_ready_busy", 64'({bus.req_ready, bus.busy}), 64'(2'b10));
        @(negedge clk);
        rst_n = 1'b1;
        slog.delete();
        repeat (8) begin
            @(negedge clk);
            chk("rstm_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        chk("rstm_no_strobe", 64'(slog.size()), 64'(0));
        chk("rstm_empty", 64'({bus.req_ready, bus.busy}), 64'(2'b10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_reg_bus_master.md
Name: dma_reg_bus_master

Overview:
- Upstream master for the DMA register-access bus (wr_en/rd_en/addr/wdata/rdata).
- Accepts register read/write requests from the configuration sequencer or CPU bridge on a valid/ready channel.
- Buffers requests in a small FIFO and converts each into a single-cycle bus strobe.
- Captures read data after a fixed slave latency and returns it on a valid/ready response channel.

Parameters:
- ADDR_W, 32, register-bus address width.
- DATA_W, 32, register-bus data width.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, range 2..16.
- RD_LATENCY, 1, cycles from the rd_en cycle to the rdata-valid cycle; range 1..4.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO can accept.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  captured read data.
- wr_en  out  1  bus write strobe.
- rd_en  out  1  bus read strobe.
- addr  out  ADDR_W  bus address.
- wdata  out  DATA_W  bus write data.
- rdata  in  DATA_W  bus read data.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async assert, sync deassert at the module boundary):
  - FIFO is emptied and the FSM enters IDLE.
  - req_ready=1.
  - wr_en=rd_en=0, addr=0, wdata=0.
  - rsp_valid=0, rsp_rdata=0, busy=0.
- Request FIFO:
  - Push on req_valid&&req_ready.
  - req_ready = !full, computed from current occupancy. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Bus outputs are registered. wr_en and rd_en are never high together. Each strobe lasts exactly one cycle.
  - addr and wdata are valid only while a strobe is high and are 0 otherwise.
  - For reads, wdata=0.
- FSM states IDLE, ISSUE, RD_WAIT, RSP:
  - IDLE: if the FIFO is non-empty, pop the head and go to ISSUE. Next cycle, drive wr_en or rd_en with that entry's addr/wdata.
  - ISSUE, write: if the FIFO is non-empty, pop the next entry and stay in ISSUE. This gives back-to-back writes, one per cycle. Otherwise go to IDLE.
  - ISSUE, read: go to RD_WAIT and load the latency counter with RD_LATENCY.
  - RD_WAIT: the counter decrements each cycle. When rd_en was high in cycle T, rdata is sampled at the posedge ending cycle T+RD_LATENCY into rsp_rdata. rsp_valid rises the following cycle, and the FSM goes to RSP.
  - RSP: hold rsp_valid and rsp_rdata stable until rsp_valid&&rsp_ready, then go to IDLE.
- Reads are blocking:
  - No bus strobe is issued from the first read strobe until the response handshake completes.
  - Requests may still be pushed into the FIFO during this time.
- Ordering: bus transactions appear in exact push order. Responses appear in order of the reads.
- Minimum latency:
  - Request pushed at edge E, FIFO previously empty and FSM in IDLE: strobe is high in the cycle after edge E+1, i.e. 2 cycles from push.
  - Read response, RD_LATENCY=1: rsp_valid is high 2 cycles after the rd_en cycle.
- Reset mid-operation:
  - Any in-flight read is aborted with no response.
  - Queued requests are discarded and strobes drop immediately.
- busy=0 only when the FIFO is empty, the FSM is in IDLE, and no strobe is high.

Test Plan:
- Single write: push (W, 0x10, 0xDEADBEEF) -> exactly one cycle of wr_en=1, addr=0x10, wdata=0xDEADBEEF two cycles after the push. rsp_valid stays 0. busy returns to 0 after the strobe.
- Read, RD_LATENCY=1: push (R, 0x04); slave drives rdata=0x12345678 in the cycle after rd_en -> one rd_en pulse with addr=0x04. rsp_valid=1 with rsp_rdata=0x12345678 next cycle, held 3 cycles while rsp_ready=0, released on handshake.
- Back-to-back writes: push 4 writes to 0x0, 0x4, 0x8, 0xC on consecutive cycles -> 4 consecutive wr_en cycles in order. req_ready never drops with FIFO_DEPTH=4.
- Full/blocking: push a read, then 5 writes with rsp_ready=0 -> after 4 writes queue, req_ready=0 and the 5th write stalls. No strobe occurs until the response handshake. The writes then issue in order.
- Mixed order: W 0x20, R 0x24, W 0x28 -> strobe sequence wr, rd, wr. The second wr appears only after the read response handshake.
- Reset mid-read: assert rst_n=0 during RD_WAIT -> all outputs go to reset values asynchronously. No rsp_valid follows. The FIFO is empty after release (req_ready=1, busy=0).
